// File: rtl/fetch_issue_pkg.sv
// Shared definitions for the fetch issue stage: FSM encodings, pre-decode bit map,
// RV32IM major opcodes and small PC helpers.
package fetch_issue_pkg;

  localparam int OPC_INFO_BITS = 10;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam int INFO_BRANCH  = 0;
  localparam int INFO_JAL     = 1;
  localparam int INFO_JALR    = 2;
  localparam int INFO_LOAD    = 3;
  localparam int INFO_STORE   = 4;
  localparam int INFO_MUL     = 5;
  localparam int INFO_DIV     = 6;
  localparam int INFO_CSR     = 7;
  localparam int INFO_RD_NZ   = 8;
  localparam int INFO_ILLEGAL = 9;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pred;
  } req_tag_t;

  function automatic logic [31:0] pair_align(input logic [31:0] pc);
    return pc & ~32'd7;
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Pre-decodes one RV32IM instruction into the per-slot info vector consumed by the
// fetch FIFO and decode.
module fetch_predecode
  import fetch_issue_pkg::*;
#(
  parameter int OPC_INFO_W = 10
) (
  input  logic [31:0]           inst_i,
  output logic [OPC_INFO_W-1:0] info_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_muldiv;
  logic       known;
  logic       writes_rd;
  logic [OPC_INFO_BITS-1:0] info;
  logic       unused_fields;

  assign opcode        = inst_i[6:0];
  assign rd            = inst_i[11:7];
  assign funct3        = inst_i[14:12];
  assign funct7        = inst_i[31:25];
  assign is_muldiv     = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  assign unused_fields = ^inst_i[24:15];

  always_comb begin
    info      = '0;
    known     = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        known     = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        known          = 1'b1;
        writes_rd      = 1'b1;
        info[INFO_JAL] = 1'b1;
      end
      OPC_JALR: begin
        known           = (funct3 == 3'd0);
        writes_rd       = 1'b1;
        info[INFO_JALR] = 1'b1;
      end
      OPC_BRANCH: begin
        known             = (funct3 != 3'd2) && (funct3 != 3'd3);
        info[INFO_BRANCH] = 1'b1;
      end
      OPC_LOAD: begin
        known           = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        writes_rd       = 1'b1;
        info[INFO_LOAD] = 1'b1;
      end
      OPC_STORE: begin
        known            = (funct3 <= 3'd2);
        info[INFO_STORE] = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift-immediate forms constrain funct7.
        if (funct3 == 3'd1)      known = (funct7 == F7_BASE);
        else if (funct3 == 3'd5) known = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                     known = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP: begin
        known = (funct7 == F7_BASE) || is_muldiv ||
                ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        writes_rd      = 1'b1;
        info[INFO_MUL] = is_muldiv && !funct3[2];
        info[INFO_DIV] = is_muldiv && funct3[2];
      end
      OPC_MISC_MEM: known = 1'b1;
      OPC_SYSTEM: begin
        known          = (funct3 != 3'd4);
        info[INFO_CSR] = (funct3 != 3'd0);
        writes_rd      = (funct3 != 3'd0);
      end
      default: known = 1'b0;
    endcase
    info[INFO_RD_NZ]   = writes_rd && (rd != 5'd0);
    info[INFO_ILLEGAL] = !known;
  end

  for (genvar gi = 0; gi < OPC_INFO_W; gi++) begin : g_info
    if (gi < OPC_INFO_BITS) begin : g_bit
      assign info_o[gi] = info[gi];
    end else begin : g_pad
      assign info_o[gi] = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_issue.sv
// Fetch producer: owns the fetch PC, keeps one I-cache pair read in flight and pushes
// responses (with PC, prediction and pre-decode) into the fetch FIFO.
module fetch_issue
  import fetch_issue_pkg::*;
#(
  parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000,
  parameter int          OPC_INFO_W  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  branch_request_i,
  input  logic [31:0]           branch_pc_i,
  input  logic                  bp_taken_i,
  input  logic                  bp_slot_i,
  input  logic [31:0]           bp_target_i,
  output logic                  icache_rd_o,
  output logic [31:0]           icache_pc_o,
  input  logic                  icache_accept_i,
  input  logic                  icache_valid_i,
  input  logic [63:0]           icache_inst_i,
  output logic                  fifo_flush_o,
  output logic                  fifo_push_o,
  input  logic                  fifo_accept_i,
  output logic [31:0]           fifo_pc_o,
  output logic [1:0]            fifo_pred_o,
  output logic [63:0]           fifo_data_o,
  output logic [OPC_INFO_W-1:0] fifo_info0_o,
  output logic [OPC_INFO_W-1:0] fifo_info1_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  req_tag_t    tag_q, tag_d;
  logic [63:0] skid_q, skid_d;
  logic        push;
  logic        outstanding;
  logic [63:0] push_data;
  logic [OPC_INFO_W-1:0] info [2];

  // A redirect orphans any read that is in flight now or is being accepted this cycle.
  assign outstanding = ((state_q == ST_WAIT) && !icache_valid_i) ||
                       ((state_q == ST_DROP) && !icache_valid_i) ||
                       ((state_q == ST_RUN)  && icache_accept_i);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    skid_d  = skid_q;
    push    = 1'b0;
    if (branch_request_i) begin
      pc_d    = branch_pc_i;
      skid_d  = '0;
      state_d = outstanding ? ST_DROP : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (icache_accept_i) begin
            tag_d.pc   = pc_q;
            tag_d.pred = {bp_taken_i & bp_slot_i, bp_taken_i & ~bp_slot_i};
            pc_d       = bp_taken_i ? bp_target_i : pc_q + 32'd8;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (icache_valid_i) begin
            if (fifo_accept_i) begin
              push    = 1'b1;
              state_d = ST_RUN;
            end else begin
              skid_d  = icache_inst_i;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (fifo_accept_i) begin
            push    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_DROP: begin
          if (icache_valid_i) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= pair_align(BOOT_VECTOR);
      tag_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      skid_q  <= skid_d;
    end
  end

  assign push_data = (state_q == ST_HOLD) ? skid_q : icache_inst_i;

  // Outputs are held quiet while reset is asserted; only the request address shows.
  assign icache_rd_o  = rst_i && (state_q == ST_RUN);
  assign icache_pc_o  = pair_align(pc_q);
  assign fifo_flush_o = rst_i && branch_request_i;
  assign fifo_push_o  = rst_i && push;
  assign fifo_pc_o    = rst_i ? tag_q.pc : 32'd0;
  assign fifo_pred_o  = rst_i ? tag_q.pred : 2'd0;
  assign fifo_data_o  = rst_i ? push_data : 64'd0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_predecode
    fetch_predecode #(.OPC_INFO_W(OPC_INFO_W)) u_predecode (
      .inst_i (fifo_data_o[32*gi +: 32]),
      .info_o (info[gi])
    );
  end

  assign fifo_info0_o = info[0];
  assign fifo_info1_o = info[1];

endmodule
